// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption core: one inverse round per clock, with the key
// schedule run backwards on the fly from the round-10 key.
module aes_inv_cipher (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] ctext,
   input  logic [127:0] key10,
   output logic         busy,
   output logic         done,
   output logic [127:0] ptext
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e       state_q, state_d;
   logic [127:0] st_q, st_d, rk_q, rk_d, ptext_q, ptext_d;
   logic [3:0]   rnd_q, rnd_d;
   logic         done_q, done_d;
   logic [127:0] rkp, t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 = a^2 * a^4 * ... * a^128; zero falls out as zero.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq, acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] w;
      w = {b, b} << n;
      return w[15:8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] revkey(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, p3, rw, sw;
      {w0, w1, w2, w3} = k;
      p3 = w3 ^ w2;
      rw = {p3[23:0], p3[31:24]};
      sw = {sbox(rw[31:24]), sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])};
      return {w0 ^ sw ^ {rc, 24'h0}, w1 ^ w0, w2 ^ w1, p3};
   endfunction

   // Byte s(r,c) lives at bits [127-8*(4c+r) -: 8].
   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   m [4];
      logic [7:0]   acc;
      m[0] = 8'h0e;
      m[1] = 8'h0b;
      m[2] = 8'h0d;
      m[3] = 8'h09;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 4; i++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
               acc = acc ^ gf_mul(m[(j+4-i)%4], s[127-8*(4*c+j) -: 8]);
            end
            o[127-8*(4*c+i) -: 8] = acc;
         end
      end
      return o;
   endfunction

   always_comb begin
      rkp     = revkey(rk_q, rcon(rnd_q + 4'd1));
      t       = inv_shift_sub(st_q) ^ rkp;
      state_d = state_q;
      st_d    = st_q;
      rk_d    = rk_q;
      rnd_d   = rnd_q;
      ptext_d = ptext_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               st_d    = ctext ^ key10;
               rk_d    = key10;
               rnd_d   = 4'd9;
               state_d = StRun;
            end
         end
         StRun: begin
            rk_d = rkp;
            if (rnd_q != 4'd0) begin
               st_d  = inv_mix(t);
               rnd_d = rnd_q - 4'd1;
            end else begin
               ptext_d = t;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         st_q    <= '0;
         rk_q    <= '0;
         rnd_q   <= '0;
         ptext_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         rk_q    <= rk_d;
         rnd_q   <= rnd_d;
         ptext_q <= ptext_d;
         done_q  <= done_d;
      end
   end

   assign busy  = (state_q == StRun);
   assign done  = done_q;
   assign ptext = ptext_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed testbench for aes_inv_cipher using FIPS-197 vectors.
module tb_aes_inv_cipher;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [127:0] ctext, key10;
   logic         busy, done;
   logic [127:0] ptext;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_K  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_K   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

   aes_inv_cipher dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .ctext (ctext),
      .key10 (key10),
      .busy  (busy),
      .done  (done),
      .ptext (ptext)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " busy"}, {127'd0, busy}, 128'd0);
      check({tag, " done"}, {127'd0, done}, 128'd0);
      check({tag, " ptext"}, ptext, 128'd0);
   endtask

   // Accept a block, then expect done exactly 10 edges later with hold_pt held meanwhile.
   task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] k,
                            input logic [127:0] exp_pt, input logic [127:0] hold_pt);
      start = 1'b1;
      ctext = ct;
      key10 = k;
      tick();
      start = 1'b0;
      ctext = '0;
      key10 = '0;
      for (int i = 1; i < 10; i++) begin
         check({tag, " busy in flight"}, {127'd0, busy}, 128'd1);
         check({tag, " no early done"}, {127'd0, done}, 128'd0);
         check({tag, " ptext hold"}, ptext, hold_pt);
         tick();
      end
      check({tag, " busy last"}, {127'd0, busy}, 128'd1);
      tick();
      check({tag, " done"}, {127'd0, done}, 128'd1);
      check({tag, " busy after"}, {127'd0, busy}, 128'd0);
      check({tag, " ptext"}, ptext, exp_pt);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      ctext = '0;
      key10 = '0;
      tick();
      tick();
      rst = 1'b0;
      check_reset_outputs("reset");

      // Idle hold
      for (int i = 0; i < 20; i++) begin
         tick();
         check_reset_outputs("idle");
      end

      // C.1 single block
      run_block("c1", C1_CT, C1_K, C1_PT, 128'd0);
      tick();
      check("c1 done one cycle", {127'd0, done}, 128'd0);
      check("c1 ptext stable", ptext, C1_PT);

      // Back-to-back: C.1, then App. B started in the C.1 done cycle
      run_block("b2b first", C1_CT, C1_K, C1_PT, C1_PT);
      run_block("b2b second", B_CT, B_K, B_PT, C1_PT);
      tick();
      check("b2b done drop", {127'd0, done}, 128'd0);

      // Start during busy is ignored
      start = 1'b1;
      ctext = C1_CT;
      key10 = C1_K;
      tick();
      start = 1'b0;
      for (int i = 1; i < 10; i++) begin
         if (i == 4) begin
            start = 1'b1;
            ctext = B_CT;
            key10 = B_K;
         end else begin
            start = 1'b0;
         end
         check("busy-start no done", {127'd0, done}, 128'd0);
         tick();
      end
      start = 1'b0;
      tick();
      check("busy-start done", {127'd0, done}, 128'd1);
      check("busy-start ptext", ptext, C1_PT);
      for (int i = 0; i < 12; i++) begin
         tick();
         check("busy-start single done", {127'd0, done}, 128'd0);
         check("busy-start idle", {127'd0, busy}, 128'd0);
      end

      // Reset mid-operation
      start = 1'b1;
      ctext = C1_CT;
      key10 = C1_K;
      tick();
      start = 1'b0;
      for (int i = 1; i < 5; i++) tick();
      rst = 1'b1;
      tick();
      check_reset_outputs("abort");
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         check_reset_outputs("abort quiet");
      end

      // rst and start together: rst wins
      rst   = 1'b1;
      start = 1'b1;
      ctext = B_CT;
      key10 = B_K;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      check_reset_outputs("rst+start");
      tick();
      check("rst+start not accepted", {127'd0, busy}, 128'd0);

      // Fresh App. B after abort
      run_block("appb", B_CT, B_K, B_PT, 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: timeout got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
